// File: rtl/encoder8_3_rr.sv
// encoder8_3_rr: registered 8-to-3 request encoder with sticky pending set,
// round-robin (or fixed) priority and a valid/ready output handshake.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   req      [7:0] request lines, OR-ed into the pending set every edge
//   ready    consumer accepts idx this cycle
//   idx      [2:0] registered index of the granted source
//   valid    registered, idx is meaningful
//   pending  [7:0] registered sticky pending set
//
// Build option: define ENCODER_RR_EN for round-robin priority. When it is
// undefined, the lowest pending index always wins and no pointer is kept.

module encoder8_3_rr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       ready,
    output logic [2:0] idx,
    output logic       valid,
    output logic [7:0] pending
);

    // The output state is just valid_q, named for readability.
    typedef enum logic {
        EMPTY   = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  pending_q;
    logic [7:0]  pending_d;
    logic [2:0]  idx_q;
    logic [2:0]  idx_d;

    logic        hs;
    logic        load;
    logic        any;
    logic [7:0]  clr;
    logic [7:0]  cand;
    logic [2:0]  base;
    logic [15:0] dbl;
    logic [7:0]  rot;
    logic [2:0]  off;
    logic [2:0]  pick;

    assign hs   = (state_q == PRESENT) & ready;
    assign load = (state_q == EMPTY) | ready;

    // The accepted bit is dropped from the candidates so it is never
    // re-issued on the same edge; a new req for it re-pends it below.
    assign clr  = hs ? (8'd1 << idx_q) : 8'd0;
    assign cand = pending_q & ~clr;
    assign any  = |cand;

`ifdef ENCODER_RR_EN
    logic [2:0] ptr_q;

    // After an accept the search starts just past the accepted index,
    // even on the accept edge itself (ptr_q only catches up next cycle).
    assign base = hs ? idx_q + 3'd1 : ptr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 3'd0;
        end else if (hs) begin
            ptr_q <= idx_q + 3'd1;
        end
    end
`else
    assign base = 3'd0;
`endif

    // Rotate so that bit 'base' lands at position 0; the lowest set bit
    // of the rotated vector is then the first hit of the wrapped scan.
    assign dbl = {cand, cand} >> base;
    assign rot = dbl[7:0];

    always_comb begin
        off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) begin
                off = 3'(i);
            end
        end
    end

    // 3-bit add wraps 7 -> 0 naturally.
    assign pick = base + off;

    // Set wins over clear: a req on the accepted line re-pends it.
    assign pending_d = cand | req;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            pending_q <= 8'd0;
            idx_q     <= 3'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            EMPTY: begin
                if (any) begin
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (ready) begin
                    state_d = any ? PRESENT : EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        if (load) begin
            idx_d = any ? pick : 3'd0;
        end
    end

    // Outputs are pure register taps.
    always_comb begin
        valid   = (state_q == PRESENT);
        idx     = idx_q;
        pending = pending_q;
    end

endmodule

// File: tb/tb_encoder8_3_rr.sv
// tb_encoder8_3_rr: scoreboard bench for encoder8_3_rr with a behavioural
// model of the pending set, grant register and search pointer.

module tb_encoder8_3_rr;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       ready;
    logic [2:0] idx;
    logic       valid;
    logic [7:0] pending;

    int vectors = 0;
    int errors  = 0;
    bit started = 0;

    logic [2:0] exp_q[$];

    // Behavioural model state.
    bit m_pend[8];
    bit m_valid;
    int m_idx;
    int m_ptr;

    encoder8_3_rr dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .ready   (ready),
        .idx     (idx),
        .valid   (valid),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    function automatic logic [7:0] m_pend_vec();
        logic [7:0] v;
        v = 8'd0;
        for (int i = 0; i < 8; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // One clock edge of the reference behaviour.
    task automatic model_step(input logic [7:0] r, input logic rd,
                              input logic rs);
        bit cand[8];
        bit hs;
        int base;
        int found;
        int old_idx;
        if (!rs) begin
            for (int i = 0; i < 8; i++) m_pend[i] = 0;
            m_valid = 0;
            m_idx   = 0;
            m_ptr   = 0;
            return;
        end
        hs      = m_valid && rd;
        old_idx = m_idx;
        for (int i = 0; i < 8; i++) cand[i] = m_pend[i];
        if (hs) cand[old_idx] = 0;
`ifdef ENCODER_RR_EN
        base = hs ? (old_idx + 1) % 8 : m_ptr;
`else
        base = 0;
`endif
        for (int i = 0; i < 8; i++) m_pend[i] = cand[i] | r[i];
        if (!m_valid || rd) begin
            found = -1;
            for (int k = 0; k < 8; k++) begin
                if (found < 0 && cand[(base + k) % 8]) found = (base + k) % 8;
            end
            m_valid = (found >= 0);
            m_idx   = (found >= 0) ? found : 0;
        end
        if (hs) m_ptr = (old_idx + 1) % 8;
    endtask

    // Drive one cycle; expected accepts go to the scoreboard queue.
    task automatic cyc(input logic [7:0] r, input logic rd, input logic rs);
        req   = r;
        ready = rd;
        rst_n = rs;
        if (rs && m_valid && rd) exp_q.push_back(3'(m_idx));
        @(posedge clk);
        model_step(r, rd, rs);
        #1;
        started = 1;
    endtask

    // Monitor: mid-cycle compare against the model and pop on accepts.
    always @(negedge clk) begin
        if (started) begin
            chk("valid", {7'd0, valid}, {7'd0, m_valid});
            if (m_valid) chk("idx", {5'd0, idx}, 8'(m_idx));
            chk("pending", pending, m_pend_vec());
            if (valid === 1'b1 && ready && rst_n) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL accept: got idx %0d expected no accept",
                             idx);
                end else begin
                    chk("accept", {5'd0, idx}, {5'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        m_valid = 0;
        m_idx   = 0;
        m_ptr   = 0;
        for (int i = 0; i < 8; i++) m_pend[i] = 0;

        // Reset with all requests high.
        cyc(8'hFF, 1'b1, 1'b0);
        cyc(8'hFF, 1'b1, 1'b0);
        chk("rst_pending", pending, 8'h00);
        chk("rst_valid", {7'd0, valid}, 8'h00);
        chk("rst_idx", {5'd0, idx}, 8'h00);
        cyc(8'h00, 1'b0, 1'b1);
        cyc(8'h00, 1'b1, 1'b1);
        chk("idle_pending", pending, 8'h00);
        chk("idle_valid", {7'd0, valid}, 8'h00);

        // Single pulse.
        cyc(8'h20, 1'b1, 1'b1);
        chk("sp_pending", pending, 8'h20);
        chk("sp_valid0", {7'd0, valid}, 8'h00);
        cyc(8'h00, 1'b1, 1'b1);
        chk("sp_valid1", {7'd0, valid}, 8'h01);
        chk("sp_idx", {5'd0, idx}, 8'h05);
        cyc(8'h00, 1'b1, 1'b1);
        chk("sp_valid2", {7'd0, valid}, 8'h00);
        chk("sp_pending2", pending, 8'h00);

        // Round-robin sequence from a fresh pointer.
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h83, 1'b1, 1'b1);
        cyc(8'h00, 1'b1, 1'b1);
        chk("rr_idx0", {5'd0, idx}, 8'd0);
        cyc(8'h00, 1'b1, 1'b1);
        chk("rr_idx1", {5'd0, idx}, 8'd1);
        cyc(8'h00, 1'b1, 1'b1);
        chk("rr_idx7", {5'd0, idx}, 8'd7);
        cyc(8'h00, 1'b1, 1'b1);
        chk("rr_empty", {7'd0, valid}, 8'h00);
        cyc(8'h81, 1'b1, 1'b1);
        cyc(8'h00, 1'b1, 1'b1);
        chk("rr2_idx0", {5'd0, idx}, 8'd0);
        cyc(8'h00, 1'b1, 1'b1);
        chk("rr2_idx7", {5'd0, idx}, 8'd7);
        cyc(8'h00, 1'b1, 1'b1);

        // Backpressure: idx 2 held, pending accumulates.
        cyc(8'h0C, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b1);
        chk("bp_idx", {5'd0, idx}, 8'd2);
        cyc(8'h01, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b1);
        chk("bp_hold_idx", {5'd0, idx}, 8'd2);
        chk("bp_hold_valid", {7'd0, valid}, 8'h01);
        chk("bp_pending", pending, 8'h0D);
        cyc(8'h00, 1'b1, 1'b1);
`ifdef ENCODER_RR_EN
        chk("bp_next_a", {5'd0, idx}, 8'd3);
        cyc(8'h00, 1'b1, 1'b1);
        chk("bp_next_b", {5'd0, idx}, 8'd0);
`else
        chk("bp_next_a", {5'd0, idx}, 8'd0);
        cyc(8'h00, 1'b1, 1'b1);
        chk("bp_next_b", {5'd0, idx}, 8'd3);
`endif
        cyc(8'h00, 1'b1, 1'b1);
        chk("bp_done", {7'd0, valid}, 8'h00);

        // Simultaneous set/clear on index 4.
        cyc(8'h10, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b1);
        chk("sc_idx4", {5'd0, idx}, 8'd4);
        cyc(8'h12, 1'b1, 1'b1);
        chk("sc_repend", pending & 8'h10, 8'h10);
        cyc(8'h00, 1'b1, 1'b1);
        cyc(8'h00, 1'b1, 1'b1);
        cyc(8'h00, 1'b1, 1'b1);

        // Reset mid-stream.
        cyc(8'hFF, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b1);
        chk("ms_pending", pending, 8'hFF);
        chk("ms_valid", {7'd0, valid}, 8'h01);
        cyc(8'h00, 1'b1, 1'b0);
        chk("ms_rst_pending", pending, 8'h00);
        chk("ms_rst_valid", {7'd0, valid}, 8'h00);
        chk("ms_rst_idx", {5'd0, idx}, 8'h00);
        cyc(8'h40, 1'b1, 1'b1);
        cyc(8'h00, 1'b1, 1'b1);
        chk("ms_idx6", {5'd0, idx}, 8'd6);
        cyc(8'h00, 1'b1, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
                $urandom_range(0, 2) != 0,
                $urandom_range(0, 63) != 0);
        end

        // Drain and confirm every expected accept was seen.
        for (int n = 0; n < 20; n++) cyc(8'h00, 1'b1, 1'b1);
        chk("drain", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors,
                 errors);
        $finish;
    end

endmodule
